// File: rtl/bit_reversal_stream_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bit_reversal_stream_ctrl_pkg
// Description : Shared constants and helpers for the bit-reversal streaming
//               controller and its permutation network.
// Revision    : 1.0 - initial release
// ============================================================================
package bit_reversal_stream_ctrl_pkg;

    localparam int                PERM_W        = 8;
    localparam logic [PERM_W-1:0] PERM_IDENTITY = 8'h00;
    localparam logic [PERM_W-1:0] PERM_FULL     = 8'hFF;

    // Counter width for a frame of 'size' words (at least one bit)
    function automatic int cnt_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    // Source word index feeding output word 'idx'. Bit b of 'perm' swaps
    // index bits b and (log2n-1-b); with every pair enabled the result is
    // a full bit reversal, with none it is the identity. Each stage is a
    // bit swap, so any perm value gives a true permutation.
    function automatic int perm_src_index(input int idx, input int log2n,
                                          input logic [PERM_W-1:0] perm);
        int src;
        int hi;
        src = idx;
        for (int b = 0; b < PERM_W / 2; b++) begin
            hi = log2n - 1 - b;
            if (perm[b] && (b < hi)) begin
                if (((src >> b) & 1) != ((src >> hi) & 1)) begin
                    src = src ^ ((1 << b) | (1 << hi));
                end
            end
        end
        return src;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_reversal.sv
`default_nettype none
// ============================================================================
// Module      : bit_reversal
// Description : Combinational permutation network. Output word j is taken
//               from input word perm_src_index(j, log2(SIZE), perm_enable).
// Revision    : 1.0 - initial release
// ============================================================================
module bit_reversal
    import bit_reversal_stream_ctrl_pkg::*;
#(
    parameter int SIZE  = 256,
    parameter int WIDTH = 32
) (
    input  logic [SIZE*WIDTH-1:0] input_list,
    input  logic [PERM_W-1:0]     perm_enable,
    output logic [SIZE*WIDTH-1:0] output_list
);

    localparam int c_log2n = $clog2(SIZE);
    localparam int c_idx_w = cnt_width(SIZE);

    generate
        for (genvar j = 0; j < SIZE; j++) begin : g_lane
            logic [c_idx_w-1:0] w_src;

            // Select the source word for this output lane
            always_comb begin
                w_src = c_idx_w'(perm_src_index(j, c_log2n, perm_enable));
            end

            assign output_list[j*WIDTH +: WIDTH] = input_list[w_src*WIDTH +: WIDTH];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/bit_reversal_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bit_reversal_stream_ctrl
// Description : Double-buffered streaming wrapper around bit_reversal. Loads
//               one frame word-serially, permutes it in a single transfer
//               cycle into the output buffer, and drains it word-serially
//               while the next frame loads.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_reversal_stream_ctrl
    import bit_reversal_stream_ctrl_pkg::*;
#(
    parameter int SIZE  = 256,
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PERM_W-1:0] cfg_perm,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_last,
    output logic              frame_err,
    output logic              busy
);

    localparam int                 c_cnt_w = cnt_width(SIZE);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(SIZE - 1);

    logic [c_cnt_w-1:0]  r_in_cnt;
    logic [c_cnt_w-1:0]  r_out_cnt;
    logic                r_in_full;
    logic                r_out_full;
    logic                r_frame_err;
    logic [PERM_W-1:0]   r_in_perm;
    logic [WIDTH-1:0]    r_in_buf  [SIZE];
    logic [WIDTH-1:0]    r_out_buf [SIZE];

    logic [SIZE*WIDTH-1:0] w_in_flat;
    logic [SIZE*WIDTH-1:0] w_perm_flat;
    logic                  w_in_fire;
    logic                  w_in_end;
    logic                  w_out_fire;
    logic                  w_out_end;
    logic                  w_xfer;

    assign w_in_fire  = in_valid & ~r_in_full;
    assign w_in_end   = (r_in_cnt == c_last);
    assign w_out_fire = r_out_full & out_ready;
    assign w_out_end  = (r_out_cnt == c_last);
    // Uses registered out_full, so a frame completing on the same edge as
    // the last output beat transfers one edge later.
    assign w_xfer     = r_in_full & ~r_out_full;

    generate
        for (genvar j = 0; j < SIZE; j++) begin : g_flat
            assign w_in_flat[j*WIDTH +: WIDTH] = r_in_buf[j];
        end
    endgenerate

    bit_reversal #(
        .SIZE  (SIZE),
        .WIDTH (WIDTH)
    ) u_net (
        .input_list  (w_in_flat),
        .perm_enable (r_in_perm),
        .output_list (w_perm_flat)
    );

    // Input buffer storage: write the accepted word at the load pointer
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_in_buf[r_in_cnt] <= in_data;
        end
    end

    // Output buffer storage: capture the whole permuted frame on transfer
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            for (int j = 0; j < SIZE; j++) begin
                r_out_buf[j] <= w_perm_flat[j*WIDTH +: WIDTH];
            end
        end
    end

    // Input side: load counter, full flag, per-frame perm latch, framing check
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_cnt    <= '0;
            r_in_full   <= 1'b0;
            r_in_perm   <= PERM_IDENTITY;
            r_frame_err <= 1'b0;
        end else if (w_in_fire) begin
            if (r_in_cnt == '0) begin
                r_in_perm <= cfg_perm;
            end
            if (in_last != w_in_end) begin
                r_frame_err <= 1'b1;
            end
            if (w_in_end) begin
                r_in_cnt  <= '0;
                r_in_full <= 1'b1;
            end else begin
                r_in_cnt <= r_in_cnt + c_cnt_w'(1);
            end
        end else if (w_xfer) begin
            r_in_full <= 1'b0;
        end
    end

    // Output side: drain counter and full flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_cnt  <= '0;
            r_out_full <= 1'b0;
        end else if (w_xfer) begin
            r_out_cnt  <= '0;
            r_out_full <= 1'b1;
        end else if (w_out_fire) begin
            if (w_out_end) begin
                r_out_cnt  <= '0;
                r_out_full <= 1'b0;
            end else begin
                r_out_cnt <= r_out_cnt + c_cnt_w'(1);
            end
        end
    end

    assign in_ready  = ~r_in_full;
    assign out_valid = r_out_full;
    assign out_data  = r_out_buf[r_out_cnt];
    assign out_last  = r_out_full & w_out_end;
    assign frame_err = r_frame_err;
    assign busy      = (r_in_cnt != '0) | r_in_full | r_out_full;

endmodule
`default_nettype wire
